// File: rtl/shift_reg_pkg.sv
// Definitions shared by the serial shift-register blocks: FSM states and
// an elaboration-time clog2 helper.
package shift_reg_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/sipo_out_stage.sv
// Output holding register for sipo_rx: valid/ready handshake, sticky
// overrun flag and the tri-state parallel output.
module sipo_out_stage
  import shift_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter bit          CLOCK_EDGE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic                  ready_in,
  input  logic                  out_enable_in,
  output logic [DATA_WIDTH-1:0] q_out,
  output logic                  valid_out,
  output logic                  overrun_out
);

  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  // A completing word is accepted if the slot is empty or being drained on
  // the same edge; otherwise it is dropped and the held word is kept.
  always_comb begin
    q_d       = q_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load_i) begin
      if (!valid_q || ready_in) begin
        q_d     = word_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end
  end

  if (CLOCK_EDGE) begin : g_pos
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_q       <= '0;
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end else begin
        q_q       <= q_d;
        valid_q   <= valid_d;
        overrun_q <= overrun_d;
      end
    end
  end else begin : g_neg
    always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
        q_q       <= '0;
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end else begin
        q_q       <= q_d;
        valid_q   <= valid_d;
        overrun_q <= overrun_d;
      end
    end
  end

  assign q_out       = out_enable_in ? q_q : 'z;
  assign valid_out   = valid_q;
  assign overrun_out = overrun_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: frames MSB-first bits into DATA_WIDTH
// words and hands them to sipo_out_stage.
module sipo_rx
  import shift_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter bit          CLOCK_EDGE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_enable,
  input  logic                  d_in,
  input  logic                  frame_in,
  input  logic                  ready_in,
  input  logic                  out_enable_in,
  output logic [DATA_WIDTH-1:0] q_out,
  output logic                  valid_out,
  output logic                  overrun_out,
  output logic                  frame_err_out
);

  localparam int unsigned     CNT_W    = clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  // Only the low DATA_WIDTH-1 bits of the shifter are ever read, so the MSB
  // that would fall off on the next shift is not stored.
  logic [DATA_WIDTH-2:0] sh_q, sh_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  state_e                state_q, state_d;
  logic                  frame_err_q, frame_err_d;
  logic [DATA_WIDTH-1:0] word;
  logic                  sample;
  logic                  complete;

  assign sample   = clk_enable && frame_in;
  assign word     = {sh_q, d_in};
  assign complete = sample && (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

  always_comb begin
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    frame_err_d = 1'b0;
    if (sample) begin
      sh_d = word[DATA_WIDTH-2:0];
      if (state_q == ST_IDLE) begin
        cnt_d   = CNT_W'(1);
        state_d = ST_SHIFT;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (clk_enable && (state_q == ST_SHIFT)) begin
      cnt_d       = '0;
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end
  end

  if (CLOCK_EDGE) begin : g_pos
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sh_q        <= '0;
        cnt_q       <= '0;
        state_q     <= ST_IDLE;
        frame_err_q <= 1'b0;
      end else begin
        sh_q        <= sh_d;
        cnt_q       <= cnt_d;
        state_q     <= state_d;
        frame_err_q <= frame_err_d;
      end
    end
  end else begin : g_neg
    always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
        sh_q        <= '0;
        cnt_q       <= '0;
        state_q     <= ST_IDLE;
        frame_err_q <= 1'b0;
      end else begin
        sh_q        <= sh_d;
        cnt_q       <= cnt_d;
        state_q     <= state_d;
        frame_err_q <= frame_err_d;
      end
    end
  end

  assign frame_err_out = frame_err_q;

  sipo_out_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .CLOCK_EDGE(CLOCK_EDGE)
  ) u_out_stage (
    .clk          (clk),
    .rst          (rst),
    .load_i       (complete),
    .word_i       (word),
    .ready_in     (ready_in),
    .out_enable_in(out_enable_in),
    .q_out        (q_out),
    .valid_out    (valid_out),
    .overrun_out  (overrun_out)
  );

endmodule
